// File: rtl/udma_pkg.sv
// Shared types and helpers for the uDMA RX linear channel: beat size
// decoding and byte-enable generation for lane-aligned L2 writes.
package udma_pkg;

  localparam int DEF_L2_AWIDTH_NOAL = 19;
  localparam int DEF_TRANS_SIZE     = 20;

  typedef enum logic [1:0] {
    DS_BYTE  = 2'b00,
    DS_HALF  = 2'b01,
    DS_WORD  = 2'b10,
    DS_WORD2 = 2'b11
  } datasize_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_RUN_PEND = 2'b10
  } cfg_state_e;

  // Bytes carried by one beat: 1, 2 or 4 (both word encodings give 4).
  function automatic logic [2:0] nbytes(input datasize_e ds);
    case (ds)
      DS_BYTE: return 3'd1;
      DS_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Byte enables for a beat starting at byte lane addr_lo; lanes past the
  // word boundary fall off the top so a misaligned beat is truncated.
  function automatic logic [3:0] be_gen(input logic [1:0] addr_lo, input datasize_e ds);
    logic [3:0] base;
    case (ds)
      DS_BYTE: base = 4'b0001;
      DS_HALF: base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << addr_lo;
  endfunction

endpackage

// File: rtl/udma_rx_wr_stage.sv
// One-entry L2 write request register. Holds req/addr/wdata/be until the
// grant arrives and can be reloaded in the granting cycle (no bubble).
module udma_rx_wr_stage #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          load,
  input  logic [AW-1:0] addr_in,
  input  logic [31:0]   data_in,
  input  logic [3:0]    be_in,
  input  logic          gnt,
  output logic          req,
  output logic [AW-1:0] addr,
  output logic [31:0]   wdata,
  output logic [3:0]    be,
  output logic          free
);

  logic          req_reg;
  logic [AW-1:0] addr_reg;
  logic [31:0]   wdata_reg;
  logic [3:0]    be_reg;

  // The slot can take a new beat when empty or when its content leaves now.
  assign free  = ~req_reg | gnt;
  assign req   = req_reg;
  assign addr  = addr_reg;
  assign wdata = wdata_reg;
  assign be    = be_reg;

  // Load on accept, otherwise drop the request once granted; never withdrawn.
  always_ff @(posedge clk) begin
    if (srst) begin
      req_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
    end else if (load) begin
      req_reg   <= 1'b1;
      addr_reg  <= addr_in;
      wdata_reg <= data_in;
      be_reg    <= be_in;
    end else if (gnt) begin
      req_reg   <= 1'b0;
    end
  end

endmodule

// File: rtl/udma_rx_lin_ch.sv
// uDMA-core side of one peripheral RX linear channel: config FSM with a
// one-deep pending slot, address/byte counters, and beat-to-L2-write path.
module udma_rx_lin_ch
  import udma_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = DEF_L2_AWIDTH_NOAL,
  parameter int TRANS_SIZE     = DEF_TRANS_SIZE
) (
  input  logic                        sys_clk_i,
  input  logic                        rst_i,
  input  logic [L2_AWIDTH_NOAL-1:0]   cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]       cfg_size_i,
  input  logic                        cfg_continuous_i,
  input  logic                        cfg_en_i,
  input  logic                        cfg_clr_i,
  output logic                        cfg_en_o,
  output logic                        cfg_pending_o,
  output logic [L2_AWIDTH_NOAL-1:0]   cfg_curr_addr_o,
  output logic [TRANS_SIZE-1:0]       cfg_bytes_left_o,
  input  logic [31:0]                 data_i,
  input  logic [1:0]                  datasize_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic                        l2_req_o,
  input  logic                        l2_gnt_i,
  output logic [L2_AWIDTH_NOAL-3:0]   l2_addr_o,
  output logic [31:0]                 l2_wdata_o,
  output logic [3:0]                  l2_be_o,
  output logic                        eot_o
);

  cfg_state_e                state_reg;
  logic [L2_AWIDTH_NOAL-1:0] start_reg, shadow_start_reg, curr_addr_reg;
  logic [TRANS_SIZE-1:0]     size_reg, shadow_size_reg, bytes_left_reg;
  logic                      eot_reg;

  logic                      stage_free, accept, end_of_buf, en_valid;
  logic [2:0]                beat_bytes;
  logic [TRANS_SIZE-1:0]     beat_bytes_ext;
  logic [L2_AWIDTH_NOAL-1:0] next_addr;
  logic [TRANS_SIZE-1:0]     next_left;

  assign beat_bytes     = nbytes(datasize_e'(datasize_i));
  assign beat_bytes_ext = TRANS_SIZE'(beat_bytes);
  assign next_addr      = curr_addr_reg + L2_AWIDTH_NOAL'(beat_bytes);
  assign next_left      = (bytes_left_reg > beat_bytes_ext) ? bytes_left_reg - beat_bytes_ext : '0;

  assign cfg_en_o         = (state_reg != ST_IDLE);
  assign cfg_pending_o    = (state_reg == ST_RUN_PEND);
  assign cfg_curr_addr_o  = curr_addr_reg;
  assign cfg_bytes_left_o = bytes_left_reg;
  assign eot_o            = eot_reg;

  assign ready_o    = cfg_en_o & stage_free;
  assign accept     = valid_i & ready_o;
  assign end_of_buf = accept & (beat_bytes_ext >= bytes_left_reg);
  assign en_valid   = cfg_en_i & (cfg_size_i != '0);

  // Config FSM and counters; clr dominates, then end-of-buffer reload, then en.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_reg        <= ST_IDLE;
      start_reg        <= '0;
      size_reg         <= '0;
      shadow_start_reg <= '0;
      shadow_size_reg  <= '0;
      curr_addr_reg    <= '0;
      bytes_left_reg   <= '0;
      eot_reg          <= 1'b0;
    end else begin
      eot_reg <= 1'b0;
      if (cfg_clr_i) begin
        state_reg        <= ST_IDLE;
        start_reg        <= '0;
        size_reg         <= '0;
        shadow_start_reg <= '0;
        shadow_size_reg  <= '0;
        curr_addr_reg    <= '0;
        bytes_left_reg   <= '0;
      end else if (end_of_buf) begin
        eot_reg <= 1'b1;
        if (en_valid) begin
          // A same-cycle en behaves as an already-pending transfer.
          start_reg      <= cfg_startaddr_i;
          size_reg       <= cfg_size_i;
          curr_addr_reg  <= cfg_startaddr_i;
          bytes_left_reg <= cfg_size_i;
          state_reg      <= ST_RUN;
        end else if (state_reg == ST_RUN_PEND) begin
          start_reg      <= shadow_start_reg;
          size_reg       <= shadow_size_reg;
          curr_addr_reg  <= shadow_start_reg;
          bytes_left_reg <= shadow_size_reg;
          state_reg      <= ST_RUN;
        end else if (cfg_continuous_i) begin
          curr_addr_reg  <= start_reg;
          bytes_left_reg <= size_reg;
        end else begin
          curr_addr_reg  <= next_addr;
          bytes_left_reg <= '0;
          state_reg      <= ST_IDLE;
        end
      end else begin
        if (accept) begin
          curr_addr_reg  <= next_addr;
          bytes_left_reg <= next_left;
        end
        if (en_valid) begin
          case (state_reg)
            ST_IDLE: begin
              start_reg      <= cfg_startaddr_i;
              size_reg       <= cfg_size_i;
              curr_addr_reg  <= cfg_startaddr_i;
              bytes_left_reg <= cfg_size_i;
              state_reg      <= ST_RUN;
            end
            default: begin
              shadow_start_reg <= cfg_startaddr_i;
              shadow_size_reg  <= cfg_size_i;
              state_reg        <= ST_RUN_PEND;
            end
          endcase
        end
      end
    end
  end

  udma_rx_wr_stage #(
    .AW(L2_AWIDTH_NOAL - 2)
  ) u_wr_stage (
    .clk     (sys_clk_i),
    .srst    (rst_i),
    .load    (accept),
    .addr_in (curr_addr_reg[L2_AWIDTH_NOAL-1:2]),
    .data_in (data_i << {curr_addr_reg[1:0], 3'b000}),
    .be_in   (be_gen(curr_addr_reg[1:0], datasize_e'(datasize_i))),
    .gnt     (l2_gnt_i),
    .req     (l2_req_o),
    .addr    (l2_addr_o),
    .wdata   (l2_wdata_o),
    .be      (l2_be_o),
    .free    (stage_free)
  );

endmodule
